// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU and its requester arbiter.
//   - EXE_CMD encodings driven on alu_cmd
//   - bit positions of the {n,z,c,v} status nibble
//   - arbiter state encoding (IDLE / LOCK0 / LOCK1)
package alu_pkg;

  localparam logic [3:0] CMD_NOP   = 4'b0000;
  localparam logic [3:0] CMD_MOV   = 4'b0001;
  localparam logic [3:0] CMD_ADD   = 4'b0010;
  localparam logic [3:0] CMD_ADC   = 4'b0011;
  localparam logic [3:0] CMD_SUB   = 4'b0100;
  localparam logic [3:0] CMD_SBC   = 4'b0101;
  localparam logic [3:0] CMD_AND   = 4'b0110;
  localparam logic [3:0] CMD_ORR   = 4'b0111;
  localparam logic [3:0] CMD_EOR   = 4'b1000;
  localparam logic [3:0] CMD_MVN   = 4'b1001;
  localparam logic [3:0] CMD_SORT1 = 4'b1010;
  localparam logic [3:0] CMD_SORT2 = 4'b1011;

  localparam int unsigned STAT_N = 3;
  localparam int unsigned STAT_Z = 2;
  localparam int unsigned STAT_C = 1;
  localparam int unsigned STAT_V = 0;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_LOCK0 = 2'd1,
    ARB_LOCK1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_arb_grant.sv
// Grant engine for the two-port ALU arbiter: round-robin pointer, per-requester
// lock state and lock op counter.
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   i_rq_valid   request valid, one bit per requester
//   i_rq_lock    keep grant after this op, one bit per requester
//   i_rsp_valid  response register of that requester is occupied
//   i_rsp_ready  consumer takes that response this cycle
//   o_grant      combinational one-hot (or zero) grant
module alu_arb_grant
  import alu_pkg::*;
#(
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_rq_valid,
  input  logic [1:0] i_rq_lock,
  input  logic [1:0] i_rsp_valid,
  input  logic [1:0] i_rsp_ready,
  output logic [1:0] o_grant
);

  localparam int unsigned CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

  arb_state_t    r_state;
  logic          r_ptr;
  logic [CW-1:0] r_lock_cnt;

  logic [1:0] w_elig;
  logic       w_gside;
  logic       w_owner;

  // A requester may issue while its response slot is free or being drained.
  assign w_elig  = i_rq_valid & (~i_rsp_valid | i_rsp_ready);
  assign w_gside = o_grant[1];
  assign w_owner = (r_state == ARB_LOCK1);

  always_comb begin
    o_grant = '0;
    unique case (r_state)
      ARB_IDLE: begin
        if (&w_elig) o_grant[r_ptr] = 1'b1;
        else         o_grant        = w_elig;
      end
      ARB_LOCK0: o_grant[0] = w_elig[0];
      ARB_LOCK1: o_grant[1] = w_elig[1];
      default:   o_grant    = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ARB_IDLE;
      r_ptr      <= 1'b0;
      r_lock_cnt <= '0;
    end else begin
      unique case (r_state)
        ARB_IDLE: begin
          if (|o_grant) begin
            if (i_rq_lock[w_gside] && (LOCK_MAX > 1)) begin
              r_state    <= w_gside ? ARB_LOCK1 : ARB_LOCK0;
              r_lock_cnt <= CW'(1);
            end else begin
              r_ptr <= ~w_gside;
            end
          end
        end
        ARB_LOCK0, ARB_LOCK1: begin
          if (o_grant[w_owner]) begin
            if (i_rq_lock[w_owner] && (r_lock_cnt < CNT_LAST)) begin
              r_lock_cnt <= r_lock_cnt + CW'(1);
            end else begin
              r_state    <= ARB_IDLE;
              r_ptr      <= ~w_owner;
              r_lock_cnt <= '0;
            end
          end else if (!i_rq_valid[w_owner]) begin
            // Owner walked away mid-chain: give the other side the next tie.
            r_state    <= ARB_IDLE;
            r_ptr      <= ~w_owner;
            r_lock_cnt <= '0;
          end
        end
        default: begin
          r_state    <= ARB_IDLE;
          r_lock_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares the single combinational ALU between the EXE stage (port 0) and the
// auxiliary multi-cycle engines (port 1). Round-robin grant with optional
// per-requester lock for atomic op chains; results and status are captured
// into one response register per requester.
//   clk, rst                 clock / asynchronous active-low reset
//   rqX_valid/ready          request handshake (ready = grant)
//   rqX_a, rqX_b, rqX_cmd    operands and EXE_CMD
//   rqX_cin, rqX_lock        carry in, keep grant after this op
//   alu_a/b/cmd/cin          drive to the ALU (all zero when idle)
//   alu_out, alu_status      ALU result and {n,z,c,v}
//   rspX_valid/ready         response handshake
//   rspX_data/status         registered ALU result/status
// Build option ALU_ARB_PERF_EN adds saturating counters perf_grant0,
// perf_grant1 and perf_conflict (CNT_W bits each).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned N        = 32,
  parameter int unsigned LOCK_MAX = 4
`ifdef ALU_ARB_PERF_EN
  ,
  parameter int unsigned CNT_W    = 16
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rq0_valid,
  output logic         rq0_ready,
  input  logic [N-1:0] rq0_a,
  input  logic [N-1:0] rq0_b,
  input  logic [3:0]   rq0_cmd,
  input  logic         rq0_cin,
  input  logic         rq0_lock,
  input  logic         rq1_valid,
  output logic         rq1_ready,
  input  logic [N-1:0] rq1_a,
  input  logic [N-1:0] rq1_b,
  input  logic [3:0]   rq1_cmd,
  input  logic         rq1_cin,
  input  logic         rq1_lock,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_cmd,
  output logic         alu_cin,
  input  logic [N-1:0] alu_out,
  input  logic [3:0]   alu_status,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [N-1:0] rsp0_data,
  output logic [3:0]   rsp0_status,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [N-1:0] rsp1_data,
  output logic [3:0]   rsp1_status
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_grant0,
  output logic [CNT_W-1:0] perf_grant1,
  output logic [CNT_W-1:0] perf_conflict
`endif
);

  logic [1:0]   w_grant;
  logic [1:0]   w_rsp_ready;
  logic [1:0]   r_rsp_valid;
  logic [N-1:0] r_rsp_data   [2];
  logic [3:0]   r_rsp_status [2];

  assign w_rsp_ready = {rsp1_ready, rsp0_ready};

  alu_arb_grant #(
    .LOCK_MAX (LOCK_MAX)
  ) u_grant (
    .clk         (clk),
    .rst         (rst),
    .i_rq_valid  ({rq1_valid, rq0_valid}),
    .i_rq_lock   ({rq1_lock, rq0_lock}),
    .i_rsp_valid (r_rsp_valid),
    .i_rsp_ready (w_rsp_ready),
    .o_grant     (w_grant)
  );

  assign rq0_ready = w_grant[0];
  assign rq1_ready = w_grant[1];

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_cmd = CMD_NOP;
    alu_cin = 1'b0;
    if (w_grant[0]) begin
      alu_a   = rq0_a;
      alu_b   = rq0_b;
      alu_cmd = rq0_cmd;
      alu_cin = rq0_cin;
    end else if (w_grant[1]) begin
      alu_a   = rq1_a;
      alu_b   = rq1_b;
      alu_cmd = rq1_cmd;
      alu_cin = rq1_cin;
    end
  end

  // A new accept wins over a drain, so a slot can be emptied and refilled
  // on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_valid <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_rsp_data[i]   <= '0;
        r_rsp_status[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (w_grant[i]) begin
          r_rsp_data[i]   <= alu_out;
          r_rsp_status[i] <= alu_status;
          r_rsp_valid[i]  <= 1'b1;
        end else if (w_rsp_ready[i]) begin
          r_rsp_valid[i]  <= 1'b0;
        end
      end
    end
  end

  assign rsp0_valid  = r_rsp_valid[0];
  assign rsp0_data   = r_rsp_data[0];
  assign rsp0_status = r_rsp_status[0];
  assign rsp1_valid  = r_rsp_valid[1];
  assign rsp1_data   = r_rsp_data[1];
  assign rsp1_status = r_rsp_status[1];

`ifdef ALU_ARB_PERF_EN
  logic [CNT_W-1:0] r_perf_g0;
  logic [CNT_W-1:0] r_perf_g1;
  logic [CNT_W-1:0] r_perf_cf;
  logic             w_conflict;

  assign w_conflict = rq0_valid & rq1_valid & ~(&w_grant);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_g0 <= '0;
      r_perf_g1 <= '0;
      r_perf_cf <= '0;
    end else begin
      if (w_grant[0] && (r_perf_g0 != '1)) r_perf_g0 <= r_perf_g0 + CNT_W'(1);
      if (w_grant[1] && (r_perf_g1 != '1)) r_perf_g1 <= r_perf_g1 + CNT_W'(1);
      if (w_conflict && (r_perf_cf != '1)) r_perf_cf <= r_perf_cf + CNT_W'(1);
    end
  end

  assign perf_grant0   = r_perf_g0;
  assign perf_grant1   = r_perf_g1;
  assign perf_conflict = r_perf_cf;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU stub closes the loop, a reference
// arbitration model predicts each cycle's grant, and per-port scoreboard
// queues hold the expected response of every predicted accept.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int unsigned N        = 32;
  localparam int unsigned LOCK_MAX = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         rq0_valid, rq0_ready, rq0_cin, rq0_lock;
  logic         rq1_valid, rq1_ready, rq1_cin, rq1_lock;
  logic [N-1:0] rq0_a, rq0_b, rq1_a, rq1_b;
  logic [3:0]   rq0_cmd, rq1_cmd;
  logic [N-1:0] alu_a, alu_b, alu_out;
  logic [3:0]   alu_cmd, alu_status;
  logic         alu_cin;
  logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [N-1:0] rsp0_data, rsp1_data;
  logic [3:0]   rsp0_status, rsp1_status;
`ifdef ALU_ARB_PERF_EN
  logic [15:0]  perf_grant0, perf_grant1, perf_conflict;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_arbiter #(
    .N        (N),
    .LOCK_MAX (LOCK_MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rq0_valid   (rq0_valid),
    .rq0_ready   (rq0_ready),
    .rq0_a       (rq0_a),
    .rq0_b       (rq0_b),
    .rq0_cmd     (rq0_cmd),
    .rq0_cin     (rq0_cin),
    .rq0_lock    (rq0_lock),
    .rq1_valid   (rq1_valid),
    .rq1_ready   (rq1_ready),
    .rq1_a       (rq1_a),
    .rq1_b       (rq1_b),
    .rq1_cmd     (rq1_cmd),
    .rq1_cin     (rq1_cin),
    .rq1_lock    (rq1_lock),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_cmd     (alu_cmd),
    .alu_cin     (alu_cin),
    .alu_out     (alu_out),
    .alu_status  (alu_status),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp0_data   (rsp0_data),
    .rsp0_status (rsp0_status),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp1_data   (rsp1_data),
    .rsp1_status (rsp1_status)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_grant0   (perf_grant0),
    .perf_grant1   (perf_grant1),
    .perf_conflict (perf_conflict)
`endif
  );

  // Reference ALU: returns {result, n, z, c, v}; carry is ARM-style (C=1 no borrow).
  function automatic logic [N+3:0] alu_fn(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [3:0] cmd, input logic cin);
    logic [N:0]   sum;
    logic [N-1:0] bo, r;
    logic         c, v, ci, arith;
    sum = '0; bo = b; r = '0; c = 1'b0; v = 1'b0; ci = 1'b0; arith = 1'b0;
    case (cmd)
      CMD_MOV:   r = b;
      CMD_MVN:   r = ~b;
      CMD_AND:   r = a & b;
      CMD_ORR:   r = a | b;
      CMD_EOR:   r = a ^ b;
      CMD_SORT1: r = (a < b) ? a : b;
      CMD_SORT2: r = (a < b) ? b : a;
      CMD_ADD:   begin arith = 1'b1; ci = 1'b0; end
      CMD_ADC:   begin arith = 1'b1; ci = cin;  end
      CMD_SUB:   begin arith = 1'b1; bo = ~b; ci = 1'b1; end
      CMD_SBC:   begin arith = 1'b1; bo = ~b; ci = cin;  end
      default:   r = '0;
    endcase
    if (arith) begin
      sum = {1'b0, a} + {1'b0, bo} + {{N{1'b0}}, ci};
      r   = sum[N-1:0];
      c   = sum[N];
      v   = (a[N-1] == bo[N-1]) && (r[N-1] != a[N-1]);
    end
    return {r, r[N-1], (r == '0), c, v};
  endfunction

  always_comb {alu_out, alu_status} = alu_fn(alu_a, alu_b, alu_cmd, alu_cin);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference arbitration model + scoreboard ----------------
  logic [N+3:0] q0[$];
  logic [N+3:0] q1[$];
  int owner = -1;   // requester currently holding a lock, -1 when none
  int held  = 0;    // ops accepted under the current lock
  int pref  = 0;    // winner of the next tie

  always @(negedge clk) begin
    bit           pend0, pend1, e0, e1;
    bit           v[2], lk[2];
    int           g;
    logic [N+3:0] exp;
    if (!rst) begin
      q0.delete();
      q1.delete();
      owner = -1; held = 0; pref = 0;
    end else begin
      pend0 = (q0.size() != 0);
      pend1 = (q1.size() != 0);
      chk("rsp0_valid", rsp0_valid, pend0);
      chk("rsp1_valid", rsp1_valid, pend1);
      if (rsp0_valid && rsp0_ready && pend0) begin
        exp = q0.pop_front();
        chk("rsp0_data", rsp0_data, exp[N+3:4]);
        chk("rsp0_status", rsp0_status, exp[3:0]);
      end
      if (rsp1_valid && rsp1_ready && pend1) begin
        exp = q1.pop_front();
        chk("rsp1_data", rsp1_data, exp[N+3:4]);
        chk("rsp1_status", rsp1_status, exp[3:0]);
      end

      v[0] = rq0_valid; v[1] = rq1_valid; lk[0] = rq0_lock; lk[1] = rq1_lock;
      e0 = v[0] && (!pend0 || rsp0_ready);
      e1 = v[1] && (!pend1 || rsp1_ready);
      if (owner == 0)      g = e0 ? 0 : -1;
      else if (owner == 1) g = e1 ? 1 : -1;
      else if (e0 && e1)   g = pref;
      else if (e0)         g = 0;
      else if (e1)         g = 1;
      else                 g = -1;

      chk("rq0_ready", rq0_ready, (g == 0));
      chk("rq1_ready", rq1_ready, (g == 1));
      if (g < 0) begin
        chk("idle_alu_drive", {alu_a, alu_b, alu_cmd, alu_cin}, '0);
      end
      if (g == 0) q0.push_back(alu_fn(rq0_a, rq0_b, rq0_cmd, rq0_cin));
      if (g == 1) q1.push_back(alu_fn(rq1_a, rq1_b, rq1_cmd, rq1_cin));

      if (owner >= 0) begin
        if (g == owner) begin
          held++;
          if (!lk[owner] || held == LOCK_MAX) begin
            pref = 1 - owner; owner = -1; held = 0;
          end
        end else if (!v[owner]) begin
          pref = 1 - owner; owner = -1; held = 0;
        end
      end else if (g >= 0) begin
        if (lk[g] && LOCK_MAX > 1) begin
          owner = g; held = 1;
        end else begin
          pref = 1 - g;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int p, input logic v, input logic [3:0] cmd,
                     input logic [N-1:0] a, input logic [N-1:0] b,
                     input logic cin, input logic lk);
    if (p == 0) begin
      rq0_valid = v; rq0_cmd = cmd; rq0_a = a; rq0_b = b; rq0_cin = cin; rq0_lock = lk;
    end else begin
      rq1_valid = v; rq1_cmd = cmd; rq1_a = a; rq1_b = b; rq1_cin = cin; rq1_lock = lk;
    end
  endtask

  function automatic logic [N-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(N-1){1'b0}}};
      3:       return N'($urandom_range(0, 15));
      default: return N'($urandom());
    endcase
  endfunction

  task automatic settle_check(input string nm, input logic [63:0] act_sel, input logic [63:0] exp);
    chk(nm, act_sel, exp);
  endtask

  initial begin
    put(0, 1'b0, CMD_NOP, '0, '0, 1'b0, 1'b0);
    put(1, 1'b0, CMD_NOP, '0, '0, 1'b0, 1'b0);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b1;

    // reset state with no requests
    @(negedge clk); #2;
    chk("reset_rsp_valid", {rsp0_valid, rsp1_valid}, 2'b00);
    chk("reset_ready", {rq0_ready, rq1_ready}, 2'b00);
    chk("reset_alu_cmd", alu_cmd, CMD_NOP);
    chk("reset_rsp_data", {rsp0_data, rsp1_data, rsp0_status, rsp1_status}, '0);

    // alternating round-robin: ADD 5+3 vs SUB 3-5
    tick();
    put(0, 1'b1, CMD_ADD, 32'd5, 32'd3, 1'b0, 1'b0);
    put(1, 1'b1, CMD_SUB, 32'd3, 32'd5, 1'b0, 1'b0);
    @(negedge clk); #2;
    chk("first_conflict_rq0", {rq0_ready, rq1_ready}, 2'b10);
    repeat (6) tick();

    // locked SUB/SBC pair on port 0 while port 1 waits
    put(0, 1'b1, CMD_SUB, 32'h0, 32'h1, 1'b0, 1'b1);
    tick();
    put(0, 1'b1, CMD_SBC, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    put(0, 1'b1, CMD_ADD, 32'h10, 32'h20, 1'b0, 1'b0);
    tick();

    // lock held for 6 ops: forced release after LOCK_MAX accepts
    for (int i = 0; i < 6; i++) begin
      put(0, 1'b1, CMD_ADC, N'(i), 32'hFFFF_FFFF, 1'b1, 1'b1);
      tick();
    end

    // blocked by own pending response; then drain and accept together
    put(0, 1'b0, CMD_NOP, '0, '0, 1'b0, 1'b0);
    put(1, 1'b0, CMD_NOP, '0, '0, 1'b0, 1'b0);
    tick();
    put(0, 1'b1, CMD_EOR, 32'hA5A5_A5A5, 32'hFFFF_0000, 1'b0, 1'b0);
    rsp0_ready = 1'b0;
    tick();
    put(1, 1'b1, CMD_MVN, '0, 32'h1234_5678, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2;
      chk("blocked_rq0_ready", rq0_ready, 1'b0);
      chk("served_rq1_ready", rq1_ready, 1'b1);
      tick();
    end
    rsp0_ready = 1'b1;
    @(negedge clk); #2;
    chk("drain_accept_rq0", rq0_ready, 1'b1);
    tick();

    // reset mid-lock with a pending rsp1
    put(0, 1'b0, CMD_NOP, '0, '0, 1'b0, 1'b0);
    put(1, 1'b0, CMD_NOP, '0, '0, 1'b0, 1'b0);
    tick();
    put(1, 1'b1, CMD_SUB, 32'd1, 32'd9, 1'b0, 1'b0);
    rsp1_ready = 1'b0;
    tick();
    put(1, 1'b0, CMD_NOP, '0, '0, 1'b0, 1'b0);
    put(0, 1'b1, CMD_ADD, 32'd7, 32'd7, 1'b0, 1'b1);
    tick();
    put(0, 1'b1, CMD_ADD, 32'd1, 32'd1, 1'b0, 1'b1);
    @(negedge clk); #2;
    chk("pre_reset_rsp1_pending", rsp1_valid, 1'b1);
    rst = 1'b0;
    put(0, 1'b0, CMD_NOP, '0, '0, 1'b0, 1'b0);
    #1;
    chk("async_reset_rsp_valid", {rsp0_valid, rsp1_valid}, 2'b00);
    chk("async_reset_rsp_data", {rsp0_data, rsp1_data}, '0);
    chk("async_reset_rsp_status", {rsp0_status, rsp1_status}, '0);
    chk("async_reset_drive", {rq0_ready, rq1_ready, alu_cmd, alu_cin}, '0);
    tick();
    tick();
    rst = 1'b1;
    rsp1_ready = 1'b1;
    put(0, 1'b1, CMD_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 1'b0);
    put(1, 1'b1, CMD_ORR, 32'h0000_00FF, 32'hFF00_0000, 1'b0, 1'b0);
    @(negedge clk); #2;
    chk("post_reset_conflict_rq0", {rq0_ready, rq1_ready}, 2'b10);
    tick();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      put(0, ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 11)), rnd_op(), rnd_op(),
          1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
      put(1, ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 11)), rnd_op(), rnd_op(),
          1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    // drain everything
    put(0, 1'b0, CMD_NOP, '0, '0, 1'b0, 1'b0);
    put(1, 1'b0, CMD_NOP, '0, '0, 1'b0, 1'b0);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk); #2;
    settle_check("drained_q0", q0.size(), 0);
    settle_check("drained_q1", q1.size(), 0);
    chk("drained_rsp_valid", {rsp0_valid, rsp1_valid}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single combinational ALU between two requesters: port 0 (EXE stage) and port 1 (auxiliary multi-cycle engines such as the sort/compare unit). Performs round-robin grant with an optional per-requester lock for atomic multi-op chains, such as a SUB followed by an SBC for 64-bit arithmetic. Drives the ALU operands and command, and captures the result and status into a per-requester response register. Sits between the requesters and the ALU instance in the execute stage.

Parameters:
N, 32, operand/result width; must match the ALU N.
LOCK_MAX, 4, max consecutive accepted ops under one lock (>=1).
CNT_W, 16, perf counter width (used only with ALU_ARB_PERF_EN).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
rq0_valid / rq1_valid  in  1  request valid.
rq0_ready / rq1_ready  out  1  request accepted this cycle when valid&ready.
rq0_a, rq0_b / rq1_a, rq1_b  in  N  operands.
rq0_cmd / rq1_cmd  in  4  EXE_CMD encoding.
rq0_cin / rq1_cin  in  1  carry in.
rq0_lock / rq1_lock  in  1  keep grant after this op.
alu_a, alu_b  out  N  to ALU.
alu_cmd  out  4  to ALU.
alu_cin  out  1  to ALU.
alu_out  in  N  from ALU.
alu_status  in  4  {n,z,c,v} from ALU.
rsp0_valid / rsp1_valid  out  1  result pending.
rsp0_ready / rsp1_ready  in  1  consumer takes result.
rsp0_data / rsp1_data  out  N  registered alu_out.
rsp0_status / rsp1_status  out  4  registered alu_status.

Behaviour:
- Reset (rst low, async): state IDLE, prio pointer = 0, lock_cnt = 0, rspX_valid = 0, rspX_data = 0, rspX_status = 0, perf counters = 0. Reset mid-lock or with pending responses discards everything; there is no replay.
- Eligibility: rqX eligible = rqX_valid && (!rspX_valid || rspX_ready). A same-cycle drain plus new accept is legal.
- Grant (combinational) in IDLE:
  - only one eligible → grant it;
  - both eligible → grant the pointer side.
- Grant in LOCKi: only requester i is granted; the other is never ready.
- rqX_ready = grant_X. At most one ready per cycle.
- ALU drive:
  - granted: alu_a/b/cmd/cin = granted request fields;
  - no grant: alu_a = alu_b = 0, alu_cmd = 4'b0000 (ALU outputs 0), alu_cin = 0.
- Accept edge: rspX_data <= alu_out, rspX_status <= alu_status, rspX_valid <= 1. Latency is 1 cycle from accept to rsp_valid.
- rspX_valid clears on rspX_ready when there is no new accept. Data holds while valid && !ready.
- Pointer: after any accept in IDLE that does not enter a lock, pointer = other requester.
- State transitions:
  - IDLE → LOCKi: accept from i with rqi_lock = 1 and LOCK_MAX > 1; lock_cnt <= 1.
  - LOCKi, accept with lock = 1 and lock_cnt < LOCK_MAX-1: stay; lock_cnt++.
  - LOCKi, accept with lock = 0, or lock_cnt == LOCK_MAX-1 (forced release): go to IDLE, pointer = other, lock_cnt = 0.
  - LOCKi with rqi_valid low: go to IDLE, pointer = other (abandoned lock).
  - LOCKi, rqi_valid high but blocked by its own pending response: stay, no count.
- LOCK_MAX = 1: lock is ignored; the block behaves as pure round-robin.
- No arithmetic is performed here. Status and carry semantics are exactly those of the ALU.

Optional Feature:
- ALU_ARB_PERF_EN defined: adds outputs perf_grant0, perf_grant1, perf_conflict (CNT_W each).
  - perf_grant0/1 increment on each accept from 0/1.
  - perf_conflict increments each cycle both rqX_valid are high and one is refused.
  - All three saturate at 2^CNT_W-1 and reset to 0.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package alu_pkg: EXE_CMD localparams (MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000, SORT1 1010, SORT2 1011, NOP 0000), status bit indices N=3 Z=2 C=1 V=0, and arbiter state encodings IDLE/LOCK0/LOCK1.
- One sub-module, alu_arb_grant: state, pointer, lock_cnt and grant logic. The top level holds the operand mux and response registers.

Test Plan:
- Reset, no requests → all rsp_valid = 0, alu_cmd = 0000, ready = 0; pointer = 0 (check via first conflict).
- Both valid every cycle, rsp_ready = 1: rq0 ADD 5+3, rq1 SUB 3-5 → grants alternate 0,1,0,1; rsp0_data = 8, status 0000; rsp1_data = 0xFFFFFFFE, status 1000.
- rq0 locks SUB 0x0-0x1 then SBC with cin = c while rq1 is valid → the two ops are consecutive on port 0; rq1 granted on the third cycle.
- Lock held with lock = 1 for 6 ops, LOCK_MAX = 4 → release after 4th accept; rq1 granted next.
- rsp0_ready = 0 with rsp0 pending → rq0_ready = 0; rq1 is still served. Raise rsp0_ready with rq0 valid → drain and accept in the same cycle.
- Assert rst mid-lock with pending rsp1 → all outputs zero immediately (async). After release, the first conflict goes to rq0.
